uart_recv: RTL and testbench

UART_RECV -- requirements
Module: uart_recv

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_recv.sv | 164 ++++++++++++++++
 tb/tb_uart_recv.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and
// the baud divider calculation, used by both receiver and transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit, integer-truncated (50 MHz / 115200 -> 434).
    function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a third
// delay flop used to detect a synchronized falling edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    // Synchronizer chain; resets to the idle (high) line level so a reset
    // never fabricates an edge by itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign rxd_s = r_sync2;
    assign fall  = r_sync3 & ~r_sync2;

endmodule

// File: rtl/uart_recv.sv
// 8N1 UART receiver: mid-bit sampling, glitch rejection on the start bit,
// framing-error pulse on a low stop bit, early return to IDLE after the
// stop sample so back-to-back frames are not missed.
module uart_recv
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] uart_data,
    output logic       uart_done,
    output logic       frame_err
);

    localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
    localparam int CNT_W   = $clog2(BPS_CNT);
    localparam int IDX_W   = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t           r_state;
    uart_state_t           w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [7:0]            r_data;
    logic                  r_done;
    logic                  r_err;

    logic                  w_rxd_s;
    logic                  w_fall;
    logic                  w_mid;
    logic                  w_wrap;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (uart_rxd),
        .rxd_s (w_rxd_s),
        .fall  (w_fall)
    );

    assign w_mid  = (r_cnt == CNT_MID);
    assign w_wrap = (r_cnt == CNT_LAST);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; falling edges are only acted on in IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next_state = START;
                end else begin
                    w_next_state = IDLE;
                end
            end
            START: begin
                if (w_mid && w_rxd_s) begin
                    w_next_state = IDLE;
                end else if (w_wrap) begin
                    w_next_state = DATA;
                end else begin
                    w_next_state = START;
                end
            end
            DATA: begin
                if (w_wrap && (r_idx == IDX_LAST)) begin
                    w_next_state = STOP;
                end else begin
                    w_next_state = DATA;
                end
            end
            STOP: begin
                if (w_mid) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = STOP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Baud counter: held at zero in IDLE so START always begins at count 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((r_state == IDLE) || (w_next_state == IDLE)) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Bit index: zeroed during START, advances at each data-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_state == START) begin
            r_idx <= '0;
        end else if ((r_state == DATA) && w_wrap) begin
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_idx <= r_idx;
        end
    end

    // Shift register: mid-bit sample lands in the bit selected by the index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift <= '0;
        end else if ((r_state == DATA) && w_mid) begin
            r_shift[r_idx] <= w_rxd_s;
        end else begin
            r_shift <= r_shift;
        end
    end

    // Stop-bit evaluation: load data with done pulse, or error pulse only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 8'h00;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else if ((r_state == STOP) && w_mid) begin
            if (w_rxd_s) begin
                r_data <= r_shift;
                r_done <= 1'b1;
                r_err  <= 1'b0;
            end else begin
                r_data <= r_data;
                r_done <= 1'b0;
                r_err  <= 1'b1;
            end
        end else begin
            r_data <= r_data;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    assign uart_data = r_data;
    assign uart_done = r_done;
    assign frame_err = r_err;

endmodule

// File: tb/tb_uart_recv.sv
// Directed self-checking bench for uart_recv at default parameters
// (434 clocks per bit, mid-sample at count 217).
module tb_uart_recv;

    logic       clk;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] uart_data;
    logic       uart_done;
    logic       frame_err;

    int tests_run;
    int tests_failed;

    int unsigned cyc;
    int unsigned start_cyc;
    int unsigned done_cyc;
    int          done_cnt;
    int          err_cnt;
    int          both_cnt;
    logic [7:0]  done_data [0:15];

    localparam int BIT_CLKS    = 434;
    localparam int FAST_CLKS   = 425;   // ~ +2% baud
    localparam int EXP_LATENCY = 4127;  // 2 sync + 1 fall + 9*434 + 217 + 1

    uart_recv #(
        .CLK_FREQ (50_000_000),
        .UART_BPS (115200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rxd  (uart_rxd),
        .uart_data (uart_data),
        .uart_done (uart_done),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Free-running cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (uart_done) begin
            done_data[done_cnt[3:0]] <= uart_data;
            done_cyc                 <= cyc;
            done_cnt                 <= done_cnt + 1;
        end
        if (frame_err) err_cnt  <= err_cnt + 1;
        if (uart_done && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame, LSB first; line is left high afterwards.
    task automatic send_byte(input logic [7:0] d, input int bit_clks, input logic stop_val);
        start_cyc = cyc;
        uart_rxd  = 1'b0;
        wait_clks(bit_clks);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            wait_clks(bit_clks);
        end
        uart_rxd = stop_val;
        wait_clks(bit_clks);
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        uart_rxd = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
        tests_run++;
        if (uart_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 00", uart_data);
        end
        tests_run++;
        if (uart_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done: got %b expected 0", uart_done);
        end
        tests_run++;
        if (frame_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err: got %b expected 0", frame_err);
        end
    endtask

    task automatic test_single();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h55, BIT_CLKS, 1'b1);
        wait_clks(20);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL single_done_count: got %0d expected 1", done_cnt - d0);
        end
        tests_run++;
        if (done_data[d0[3:0]] !== 8'h55) begin
            tests_failed++;
            $display("FAIL single_data_at_done: got %h expected 55", done_data[d0[3:0]]);
        end
        tests_run++;
        if (uart_data !== 8'h55) begin
            tests_failed++;
            $display("FAIL single_data_hold: got %h expected 55", uart_data);
        end
        tests_run++;
        if (err_cnt - e0 !== 0) begin
            tests_failed++;
            $display("FAIL single_err_count: got %0d expected 0", err_cnt - e0);
        end
        tests_run++;
        if (done_cyc - start_cyc !== EXP_LATENCY) begin
            tests_failed++;
            $display("FAIL single_latency: got %0d expected %0d", done_cyc - start_cyc, EXP_LATENCY);
        end
    endtask

    task automatic test_back_to_back();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hA3, BIT_CLKS, 1'b1);
        send_byte(8'h0F, BIT_CLKS, 1'b1);
        wait_clks(20);
        tests_run++;
        if (done_cnt - d0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
        end
        tests_run++;
        if (done_data[d0[3:0]] !== 8'hA3) begin
            tests_failed++;
            $display("FAIL b2b_first: got %h expected a3", done_data[d0[3:0]]);
        end
        tests_run++;
        if (done_data[(d0 + 1) % 16] !== 8'h0F) begin
            tests_failed++;
            $display("FAIL b2b_second: got %h expected 0f", done_data[(d0 + 1) % 16]);
        end
        tests_run++;
        if (err_cnt - e0 !== 0) begin
            tests_failed++;
            $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_glitch();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        uart_rxd = 1'b0;
        wait_clks(100);
        uart_rxd = 1'b1;
        wait_clks(5000);
        tests_run++;
        if (done_cnt - d0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_done_count: got %0d expected 0", done_cnt - d0);
        end
        tests_run++;
        if (err_cnt - e0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_err_count: got %0d expected 0", err_cnt - e0);
        end
        tests_run++;
        if (uart_data !== 8'h0F) begin
            tests_failed++;
            $display("FAIL glitch_data: got %h expected 0f", uart_data);
        end
    endtask

    task automatic test_frame_err();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'hFF, BIT_CLKS, 1'b0);
        wait_clks(BIT_CLKS);
        tests_run++;
        if (err_cnt - e0 !== 1) begin
            tests_failed++;
            $display("FAIL ferr_err_count: got %0d expected 1", err_cnt - e0);
        end
        tests_run++;
        if (done_cnt - d0 !== 0) begin
            tests_failed++;
            $display("FAIL ferr_done_count: got %0d expected 0", done_cnt - d0);
        end
        tests_run++;
        if (uart_data !== 8'h0F) begin
            tests_failed++;
            $display("FAIL ferr_data: got %h expected 0f", uart_data);
        end
    endtask

    task automatic test_reset_midframe();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        // 0xF5 keeps bits 4..7 high, so no edge follows the reset.
        fork
            send_byte(8'hF5, BIT_CLKS, 1'b1);
            begin
                wait_clks(5 * BIT_CLKS + 200);
                rst = 1'b1;
                wait_clks(1);
                rst = 1'b0;
            end
        join
        wait_clks(BIT_CLKS);
        tests_run++;
        if ((done_cnt - d0 !== 0) || (err_cnt - e0 !== 0)) begin
            tests_failed++;
            $display("FAIL rstmid_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        tests_run++;
        if (uart_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL rstmid_data_cleared: got %h expected 00", uart_data);
        end
        d0 = done_cnt;
        send_byte(8'h3C, BIT_CLKS, 1'b1);
        wait_clks(20);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL rstmid_next_done: got %0d expected 1", done_cnt - d0);
        end
        tests_run++;
        if (uart_data !== 8'h3C) begin
            tests_failed++;
            $display("FAIL rstmid_next_data: got %h expected 3c", uart_data);
        end
    endtask

    task automatic test_baud_fast();
        int d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h81, FAST_CLKS, 1'b1);
        wait_clks(BIT_CLKS);
        tests_run++;
        if (done_cnt - d0 !== 1) begin
            tests_failed++;
            $display("FAIL fast_done_count: got %0d expected 1", done_cnt - d0);
        end
        tests_run++;
        if (uart_data !== 8'h81) begin
            tests_failed++;
            $display("FAIL fast_data: got %h expected 81", uart_data);
        end
        tests_run++;
        if (err_cnt - e0 !== 0) begin
            tests_failed++;
            $display("FAIL fast_err_count: got %0d expected 0", err_cnt - e0);
        end
    endtask

    task automatic test_exclusive_pulses();
        tests_run++;
        if (both_cnt !== 0) begin
            tests_failed++;
            $display("FAIL exclusive_pulses: got %0d overlaps expected 0", both_cnt);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        done_cnt     = 0;
        err_cnt      = 0;
        both_cnt     = 0;
        done_cyc     = 0;
        start_cyc    = 0;
        for (int i = 0; i < 16; i++) done_data[i] = 8'h00;
        rst      = 1'b1;
        uart_rxd = 1'b1;
        @(negedge clk);

        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_midframe();
        test_baud_fast();
        test_exclusive_pulses();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
